// File: rtl/fifo_frame_reader_if.sv
// Framed-FIFO read port plus downstream valid/ready stream bundled for fifo_frame_reader.
// master is the reader's view; slave is the FIFO/sink side.
interface fifo_frame_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_empty;
    logic [DATA_WIDTH-1:0] in_dout;
    logic                  in_sof;
    logic                  in_eof;
    logic                  in_rd_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eof;

    modport master (
        input  in_empty, in_dout, in_sof, in_eof, out_ready,
        output in_rd_en, out_valid, out_data, out_sof, out_eof
    );

    modport slave (
        output in_empty, in_dout, in_sof, in_eof, out_ready,
        input  in_rd_en, out_valid, out_data, out_sof, out_eof
    );
endinterface

// File: rtl/fifo_frame_reader.sv
// Pops tagged words from a FWFT framed FIFO, enforces a fixed frame length and
// re-emits a registered valid/ready stream; stray words are dropped and counted.
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_SIZE = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fifo_frame_reader_if.master   bus,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [15:0]           frame_count,
    output logic [15:0]           drop_count
);
    localparam int CW = $clog2(FRAME_SIZE + 1);
    localparam logic [CW:0] LAST = (CW + 1)'(FRAME_SIZE);

    typedef enum logic {HUNT, FRAME} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_err_q, frame_err_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic                  can_out;
    logic                  pop;
    logic [CW:0]           pos;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sof_q     <= out_sof_d;
            out_eof_q     <= out_eof_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q & ~bus.out_ready;
        out_data_d    = out_data_q;
        out_sof_d     = out_sof_q;
        out_eof_d     = out_eof_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        pop           = 1'b0;
        pos           = '0;
        can_out       = ~out_valid_q | bus.out_ready;

        if (!bus.in_empty) begin
            if (state_q == HUNT && !bus.in_sof) begin
                // Outside a frame the word never reaches the output, so backpressure is irrelevant.
                pop          = 1'b1;
                drop_count_d = sat_inc16(drop_count_q);
            end else if (can_out) begin
                pop         = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = bus.in_dout;
                out_sof_d   = bus.in_sof;
                out_eof_d   = 1'b0;
                state_d     = FRAME;
                if (bus.in_sof) begin
                    // A SOF inside a frame means the previous frame was cut short.
                    frame_err_d = (state_q == FRAME);
                    pos         = (CW + 1)'(1);
                end else begin
                    pos = {1'b0, cnt_q} + (CW + 1)'(1);
                end
                cnt_d = pos[CW-1:0];

                if (bus.in_eof) begin
                    out_eof_d = 1'b1;
                    state_d   = HUNT;
                    cnt_d     = '0;
                    if (pos == LAST) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (pos == LAST) begin
                    // Oversize: close the frame here; the tail is dropped in HUNT.
                    out_eof_d   = 1'b1;
                    frame_err_d = 1'b1;
                    state_d     = HUNT;
                    cnt_d       = '0;
                end
            end
        end
    end

    // Gated by reset so nothing is popped (and lost uncounted) while held in reset.
    assign bus.in_rd_en  = pop & reset_n;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign frame_done    = frame_done_q;
    assign frame_err     = frame_err_q;
    assign frame_count   = frame_count_q;
    assign drop_count    = drop_count_q;
endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: table of framed scenarios, reset corner case and
// randomized traffic checked against a word-list reference model.
module tb_fifo_frame_reader;
    localparam int DW = 8;
    localparam int FS = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic frame_done, frame_err;
    logic [15:0] frame_count, drop_count;

    always #5 clk = ~clk;

    fifo_frame_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_SIZE(FS)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .frame_count(frame_count),
        .drop_count(drop_count)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       dn;
        logic       er;
    } exp_t;

    typedef struct packed {
        logic [11:0][9:0] w;
        logic [3:0]       nw;
        logic [1:0]       rmode;
        logic             tp;
        logic [7:0]       frames;
        logic [7:0]       drops;
        logic [7:0]       errs;
        logic [7:0]       outs;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    logic [9:0] fq[$];
    exp_t       eq[$];
    bit         gap;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic drive_head();
        if (fq.size() == 0 || gap) begin
            bus.in_empty = 1'b1;
            bus.in_dout  = '0;
            bus.in_sof   = 1'b0;
            bus.in_eof   = 1'b0;
        end else begin
            bus.in_empty = 1'b0;
            {bus.in_sof, bus.in_eof, bus.in_dout} = fq[0];
        end
    endtask

    // Reference: walk the word list with the framing rules, no notion of cycles.
    task automatic build_model(output int f, output int d, output int e);
        bit   inf;
        int   n;
        exp_t x;
        logic s, en;
        inf = 0; n = 0; f = 0; d = 0; e = 0;
        eq.delete();
        foreach (fq[i]) begin
            s  = fq[i][9];
            en = fq[i][8];
            if (!inf && !s) begin
                d++;
            end else begin
                x = '0;
                x.d = fq[i][7:0];
                if (s) begin
                    if (inf) x.er = 1'b1;
                    x.s = 1'b1;
                    n = 1;
                    inf = 1;
                end else begin
                    n++;
                end
                if (en) begin
                    x.e = 1'b1;
                    if (n == FS) begin x.dn = 1'b1; f++; end
                    else x.er = 1'b1;
                    inf = 0;
                end else if (n == FS) begin
                    x.e = 1'b1;
                    x.er = 1'b1;
                    inf = 0;
                end
                if (x.er) e++;
                eq.push_back(x);
            end
        end
    endtask

    task automatic set_ready(input int rmode, input int cyc);
        case (rmode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: bus.out_ready = 1'($urandom);
        endcase
    endtask

    task automatic prepare();
        reset_n       = 1'b0;
        gap           = 0;
        fq.delete();
        drive_head();
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Entered just after a posedge; drains fq through the DUT and checks the stream.
    task automatic run_loop(input int rmode, input bit gaps, input bit strict, input bit tp,
                            input int xf, input int xd, input int xe, input int xo);
        int   mf, md, me, mo, cyc, idle, nwords, nerr, first_acc, last_acc;
        bit   v, r, rd, newp, prev_v, prev_r;
        logic [9:0] prev_w;
        exp_t x;
        build_model(mf, md, me);
        mo = eq.size();
        if (xf < 0) begin xf = mf; xd = md; xe = me; xo = mo; end
        cyc = 0; idle = 0; nwords = 0; nerr = 0; first_acc = -1; last_acc = -1;
        prev_v = 0; prev_r = 0; prev_w = '0;
        gap = 0;
        set_ready(rmode, 0);
        drive_head();
        forever begin
            @(negedge clk);
            v = bus.out_valid;
            r = bus.out_ready;
            newp = v && (!prev_v || prev_r);
            if (bus.in_empty && bus.in_rd_en)
                check("rd_en_while_empty", 1, 0);
            if (prev_v && !prev_r)
                check("stall_hold", {v, bus.out_sof, bus.out_eof, bus.out_data}, {1'b1, prev_w});
            if (v && !r && !bus.in_empty && (strict || bus.in_sof))
                check("rd_en_in_stall", bus.in_rd_en, 0);
            if (newp) begin
                nwords++;
                if (eq.size() == 0) check("extra_word", {bus.out_sof, bus.out_eof, bus.out_data}, 0);
                else begin
                    x = eq.pop_front();
                    check("word", {bus.out_data, bus.out_sof, bus.out_eof, frame_done, frame_err}, x);
                end
            end else begin
                check("pulse_idle", {frame_done, frame_err}, 0);
            end
            if (frame_err) nerr++;
            if (v && r) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            prev_v = v; prev_r = r;
            prev_w = {bus.out_sof, bus.out_eof, bus.out_data};
            rd = bus.in_rd_en;
            if (fq.size() == 0 && !v) idle++; else idle = 0;
            if (idle > 3) break;
            if (cyc > 400) begin check("drain_timeout", cyc, 0); break; end
            @(posedge clk);
            #1;
            if (rd && fq.size() != 0) void'(fq.pop_front());
            cyc++;
            set_ready(rmode, cyc);
            gap = gaps ? ($urandom_range(0, 3) == 0) : 0;
            drive_head();
        end
        check("missing_words", eq.size(), 0);
        check("frame_count", frame_count, xf);
        check("drop_count", drop_count, xd);
        check("err_pulses", nerr, xe);
        check("out_words", nwords, xo);
        if (tp) check("back_to_back", last_acc - first_acc, xo - 1);
    endtask

    task automatic add(input int idx, input logic [1:0] fl, input logic [7:0] d);
        tbl[idx].w[tbl[idx].nw] = {fl, d};
        tbl[idx].nw = tbl[idx].nw + 4'd1;
    endtask

    task automatic setx(input int idx, input int rm, input bit tp, input int f, input int d,
                        input int e, input int o);
        tbl[idx].rmode  = 2'(rm);
        tbl[idx].tp     = tp;
        tbl[idx].frames = 8'(f);
        tbl[idx].drops  = 8'(d);
        tbl[idx].errs   = 8'(e);
        tbl[idx].outs   = 8'(o);
    endtask

    task automatic add_legal(input int idx, input logic [7:0] b);
        add(idx, 2'b10, b);
        add(idx, 2'b00, b + 8'd1);
        add(idx, 2'b00, b + 8'd2);
        add(idx, 2'b01, b + 8'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pops, f, d, e, o;
        bit rd;
        for (int i = 0; i < NV; i++) tbl[i] = '0;
        add_legal(0, 8'h10);                                     setx(0, 0, 1, 1, 0, 0, 4);
        add(1, 2'b00, 8'hAA); add(1, 2'b00, 8'hBB); add_legal(1, 8'h10); setx(1, 0, 0, 1, 2, 0, 4);
        add(2, 2'b10, 8'h01); add(2, 2'b00, 8'h02); add(2, 2'b01, 8'h03); setx(2, 0, 0, 0, 0, 1, 3);
        add(3, 2'b10, 8'h20);
        for (int j = 1; j < 6; j++) add(3, 2'b00, 8'(8'h20 + j));
        add_legal(3, 8'h30);                                     setx(3, 0, 0, 1, 2, 1, 8);
        add_legal(4, 8'h10);                                     setx(4, 1, 0, 1, 0, 0, 4);
        add(5, 2'b10, 8'h40); add(5, 2'b00, 8'h41); add_legal(5, 8'h50); setx(5, 2, 0, 1, 0, 1, 6);
        add(6, 2'b11, 8'h60); add_legal(6, 8'h70);               setx(6, 0, 0, 1, 0, 1, 5);

        // Reset state with a non-SOF word waiting at the head.
        reset_n       = 1'b0;
        gap           = 0;
        bus.out_ready = 1'b1;
        bus.in_empty  = 1'b0;
        bus.in_dout   = 8'h55;
        bus.in_sof    = 1'b0;
        bus.in_eof    = 1'b0;
        #22;
        check("reset_outputs", {bus.in_rd_en, bus.out_valid, bus.out_sof, bus.out_eof,
                                frame_done, frame_err, bus.out_data}, 0);
        check("reset_counts", {frame_count, drop_count}, 0);

        for (int i = 0; i < NV; i++) begin
            prepare();
            for (int j = 0; j < int'(tbl[i].nw); j++) fq.push_back(tbl[i].w[j]);
            run_loop(int'(tbl[i].rmode), 0, tbl[i].rmode == 2'd1, tbl[i].tp,
                     int'(tbl[i].frames), int'(tbl[i].drops), int'(tbl[i].errs), int'(tbl[i].outs));
        end

        // Asynchronous reset after two words of a frame; counters are nonzero beforehand.
        fq.delete();
        add_legal(0, 8'h70);
        for (int j = 0; j < 4; j++) fq.push_back(tbl[0].w[j + 4]);
        fq.delete();
        fq.push_back({2'b10, 8'h70}); fq.push_back({2'b00, 8'h71});
        fq.push_back({2'b00, 8'h72}); fq.push_back({2'b01, 8'h73});
        fq.push_back({2'b10, 8'h80}); fq.push_back({2'b00, 8'h81});
        fq.push_back({2'b00, 8'h82}); fq.push_back({2'b01, 8'h83});
        gap = 0;
        bus.out_ready = 1'b1;
        drive_head();
        pops = 0;
        for (int g = 0; g < 20 && pops < 2; g++) begin
            #1 rd = bus.in_rd_en;
            @(posedge clk);
            #1;
            if (rd) begin void'(fq.pop_front()); pops++; end
            drive_head();
            if (pops < 2) @(negedge clk);
        end
        check("pre_reset_pops", pops, 2);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_outputs", {bus.in_rd_en, bus.out_valid, bus.out_sof, bus.out_eof,
                                   frame_done, frame_err, bus.out_data}, 0);
        check("midreset_counts", {frame_count, drop_count}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_loop(0, 0, 0, 0, 1, 2, 0, 4);

        // Randomized traffic: legal frames, orphans, truncated frames and raw tagged words.
        for (int it = 0; it < 12; it++) begin
            prepare();
            while (fq.size() < 14) begin
                case ($urandom_range(0, 3))
                    0: for (int j = 0; j < 4; j++) fq.push_back({j == 0, j == 3, 8'($urandom)});
                    1: fq.push_back({2'b00, 8'($urandom)});
                    2: begin
                        fq.push_back({2'b10, 8'($urandom)});
                        repeat ($urandom_range(0, 5)) fq.push_back({2'b00, 8'($urandom)});
                    end
                    default: fq.push_back({1'($urandom), 1'($urandom), 8'($urandom)});
                endcase
            end
            f = -1; d = -1; e = -1; o = -1;
            run_loop(2, 1, 0, 0, f, d, e, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
